// File: rtl/alu_formula_seq.sv
// Multi-cycle sequencer driving a 74181-style 4-bit ALU to evaluate
// R = ((A + B) - C) ^ D, one ALU operation per step.
module alu_formula_seq #(
  parameter int STEP_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       carry,
  output logic       borrow,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [3:0] alu_S,
  output logic       alu_M,
  output logic       alu_NotCi,
  input  logic [3:0] alu_Y,
  input  logic       alu_NotC0
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SUB   = 3'd2,
    LOGIC = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT = 4'(STEP_WAIT);

  state_t     state_q;
  logic [3:0] acc_q;
  logic [3:0] opb_q;
  logic [3:0] opc_q;
  logic [3:0] opd_q;
  logic [3:0] wcnt_q;
  logic [3:0] result_q;
  logic       carry_q;
  logic       borrow_q;
  logic       step_end;

  assign step_end = (wcnt_q == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      opd_q    <= '0;
      wcnt_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            acc_q   <= A;
            opb_q   <= B;
            opc_q   <= C;
            opd_q   <= D;
            wcnt_q  <= '0;
            state_q <= ADD;
          end else begin
            state_q <= IDLE;
          end
        end
        ADD: begin
          if (step_end) begin
            acc_q   <= alu_Y;
            carry_q <= ~alu_NotC0;
            wcnt_q  <= '0;
            state_q <= SUB;
          end else begin
            wcnt_q  <= wcnt_q + 4'd1;
          end
        end
        SUB: begin
          // active-low carry out of A-B is the borrow
          if (step_end) begin
            acc_q    <= alu_Y;
            borrow_q <= alu_NotC0;
            wcnt_q   <= '0;
            state_q  <= LOGIC;
          end else begin
            wcnt_q   <= wcnt_q + 4'd1;
          end
        end
        LOGIC: begin
          if (step_end) begin
            acc_q    <= alu_Y;
            result_q <= alu_Y;
            wcnt_q   <= '0;
            state_q  <= DONE;
          end else begin
            wcnt_q   <= wcnt_q + 4'd1;
          end
        end
        default: begin
          wcnt_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_S     = 4'b0000;
    alu_M     = 1'b1;
    alu_NotCi = 1'b1;
    case (state_q)
      ADD: begin
        alu_A     = acc_q;
        alu_B     = opb_q;
        alu_S     = 4'b1001;
        alu_M     = 1'b0;
      end
      SUB: begin
        alu_A     = acc_q;
        alu_B     = opc_q;
        alu_S     = 4'b0110;
        alu_M     = 1'b0;
        alu_NotCi = 1'b0;
      end
      LOGIC: begin
        alu_A     = acc_q;
        alu_B     = opd_q;
        alu_S     = 4'b0110;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == ADD) || (state_q == SUB) ||
                  (state_q == LOGIC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_alu_formula_seq.sv
// Bench for alu_formula_seq: two sequencers (STEP_WAIT 0 and 3),
// each paired with a behavioural 74181 model.
module tb_alu_formula_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [4:0] alu181(
    input logic [3:0] a, input logic [3:0] b,
    input logic [3:0] s, input logic m, input logic nci);
    logic [4:0] t;
    logic       cin;
    cin = ~nci;
    if (!m) begin
      case (s)
        4'b1001: t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        4'b0110: t = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        default: t = {1'b0, a} + {4'd0, cin};
      endcase
      return {~t[4], t[3:0]};
    end
    case (s)
      4'b0110: t = {1'b1, a ^ b};
      4'b0000: t = {1'b1, ~a};
      default: t = {1'b1, a};
    endcase
    return t;
  endfunction

  // instance with STEP_WAIT=0
  logic       st0;
  logic [3:0] a0, b0, c0, d0;
  logic       busy0, done0, cy0, bw0, m0, nci0, nc00;
  logic [3:0] r0, aa0, ab0, s0, y0;

  always_comb {nc00, y0} = alu181(aa0, ab0, s0, m0, nci0);

  alu_formula_seq #(.STEP_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(st0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .busy(busy0), .done(done0), .result(r0),
    .carry(cy0), .borrow(bw0),
    .alu_A(aa0), .alu_B(ab0), .alu_S(s0),
    .alu_M(m0), .alu_NotCi(nci0),
    .alu_Y(y0), .alu_NotC0(nc00)
  );

  // instance with STEP_WAIT=3
  logic       st3;
  logic [3:0] a3, b3, c3, d3;
  logic       busy3, done3, cy3, bw3, m3, nci3, nc03;
  logic [3:0] r3, aa3, ab3, s3, y3;

  always_comb {nc03, y3} = alu181(aa3, ab3, s3, m3, nci3);

  alu_formula_seq #(.STEP_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .start(st3),
    .A(a3), .B(b3), .C(c3), .D(d3),
    .busy(busy3), .done(done3), .result(r3),
    .carry(cy3), .borrow(bw3),
    .alu_A(aa3), .alu_B(ab3), .alu_S(s3),
    .alu_M(m3), .alu_NotCi(nci3),
    .alu_Y(y3), .alu_NotC0(nc03)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run0(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d,
                      output int lat);
    a0 = a; b0 = b; c0 = c; d0 = d;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  typedef struct {
    logic [3:0] a, b, c, d;
    logic [3:0] r;
    logic       cy, bw;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    int npulse, first, last, gaps_bad, unstable;
    int ndone, nbusy;
    logic [3:0] ea, eb, es;
    logic       em, en;

    tbl[0] = '{4'h7, 4'h5, 4'h3, 4'h6, 4'hF, 1'b0, 1'b0};
    tbl[1] = '{4'hF, 4'h2, 4'h4, 4'h0, 4'hD, 1'b1, 1'b1};
    tbl[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{4'h8, 4'h8, 4'h1, 4'h5, 4'hA, 1'b1, 1'b1};
    tbl[4] = '{4'h3, 4'h4, 4'h7, 4'hA, 4'hA, 1'b0, 1'b0};
    tbl[5] = '{4'h9, 4'h3, 4'h2, 4'hC, 4'h6, 1'b0, 1'b0};

    st0 = 0; a0 = 0; b0 = 0; c0 = 0; d0 = 0;
    st3 = 0; a3 = 0; b3 = 0; c3 = 0; d3 = 0;

    // reset state
    #12;
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_result", 32'(r0), 32'h0);
    chk("rst_flags", 32'({cy0, bw0}), 32'h0);
    chk("rst_pins", 32'({aa0, ab0, s0, m0, nci0}), 32'h00003);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // table of single runs
    for (int i = 0; i < 6; i++) begin
      run0(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_result", i), 32'(r0), 32'(tbl[i].r));
      chk($sformatf("v%0d_carry", i), 32'(cy0), 32'(tbl[i].cy));
      chk($sformatf("v%0d_borrow", i), 32'(bw0), 32'(tbl[i].bw));
    end
    @(posedge clk);
    #1 chk("idle_hold_result", 32'(r0), 32'h6);
    chk("idle_done_low", 32'(done0), 32'h0);

    // start held high: done every 4 cycles
    a0 = 4'h7; b0 = 4'h5; c0 = 4'h3; d0 = 4'h6;
    st0 = 1'b1;
    npulse = 0; first = 0; last = 0; gaps_bad = 0; unstable = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        if (npulse == 0) first = k;
        else if (k - last != 4) gaps_bad++;
        last = k;
        npulse++;
      end
      if (k >= 4 && r0 !== 4'hF) unstable++;
    end
    st0 = 1'b0;
    chk("b2b_pulses", 32'(npulse), 32'd3);
    chk("b2b_first", 32'(first), 32'd4);
    chk("b2b_gaps", 32'(gaps_bad), 32'd0);
    chk("b2b_stable", 32'(unstable), 32'd0);

    // STEP_WAIT=3: pins held four cycles per step
    a3 = 4'h1; b3 = 4'h1; c3 = 4'h0; d3 = 4'hF;
    st3 = 1'b1;
    @(posedge clk);
    #1 st3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ea = (k < 4) ? 4'h1 : 4'h2;
      eb = (k < 4) ? 4'h1 : (k < 8) ? 4'h0 : 4'hF;
      es = (k < 4) ? 4'b1001 : 4'b0110;
      em = (k >= 8);
      en = !(k >= 4 && k < 8);
      chk($sformatf("sw3_pins_c%0d", k),
          32'({aa3, ab3, s3, m3, nci3, done3}),
          32'({ea, eb, es, em, en, 1'b0}));
      @(posedge clk);
      #1;
    end
    chk("sw3_done", 32'(done3), 32'h1);
    chk("sw3_result", 32'(r3), 32'hD);
    chk("sw3_flags", 32'({cy3, bw3}), 32'h0);

    // reset in SUB
    a0 = 4'h9; b0 = 4'h3; c0 = 4'h2; d0 = 4'hC;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_busy", 32'(busy0), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy0), 32'h0);
    chk("mid_rst_result", 32'(r0), 32'h0);
    chk("mid_rst_pins", 32'({aa0, ab0, s0, m0, nci0}), 32'h00003);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    run0(4'hF, 4'h2, 4'h4, 4'h0, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_result", 32'({r0, cy0, bw0}), 32'({4'hD, 1'b1, 1'b1}));

    // operand changes and start while busy are ignored
    @(posedge clk);
    #1;
    a0 = 4'h3; b0 = 4'h4; c0 = 4'h7; d0 = 4'hA;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    a0 = 4'hF; b0 = 4'hF; c0 = 4'hF; d0 = 4'hF;
    @(posedge clk);
    #1 st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    @(posedge clk);
    #1 chk("busy_ign_done", 32'(done0), 32'h1);
    chk("busy_ign_result", 32'(r0), 32'hA);
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done0) ndone++;
      if (busy0) nbusy++;
    end
    chk("no_second_done", 32'(ndone), 32'd0);
    chk("no_second_busy", 32'(nbusy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
